// File: rtl/log_mag_decode_if.sv
// rtl/log_mag_decode_if.sv - handshake and data bundle for the log-magnitude decoder
interface log_mag_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_exp;
  logic [7:0]  in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_mag;
  logic        out_sat;
  logic [7:0]  sat_count;

  modport master (
    output in_valid, in_exp, in_frac, out_ready,
    input  in_ready, out_valid, out_mag, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in_exp, in_frac, out_ready,
    output in_ready, out_valid, out_mag, out_sat, sat_count
  );
endinterface

// File: rtl/log_mag_decode.sv
// rtl/log_mag_decode.sv - two-stage decoder from (exp, frac) log code to linear magnitude-squared
module log_mag_decode (
  input  logic            clk,
  input  logic            resetn,
  log_mag_decode_if.slave bus
);
  logic        en;
  logic        s1_valid;
  logic [5:0]  s1_exp;
  logic [7:0]  s1_frac;
  logic [8:0]  mant;
  logic [5:0]  shamt;
  logic [32:0] mag_next;
  logic        sat_next;
  logic        out_valid_q;
  logic [32:0] out_mag_q;
  logic        out_sat_q;
  logic [7:0]  sat_count_q;

  // A single enable freezes both stages together, so a bubble in stage 1 stalls too.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_exp   <= 6'd0;
      s1_frac  <= 8'd0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_exp   <= bus.in_exp;
      s1_frac  <= bus.in_frac;
    end
  end

  // Codes below 8 carry the value directly in the fraction byte; above 32 it cannot fit.
  always_comb begin
    mant     = {1'b1, s1_frac};
    shamt    = s1_exp - 6'd8;
    mag_next = {25'd0, s1_frac};
    sat_next = 1'b0;
    if (s1_exp > 6'd32) begin
      mag_next = {33{1'b1}};
      sat_next = 1'b1;
    end else if (s1_exp >= 6'd8) begin
      mag_next = {24'd0, mant} << shamt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_mag_q   <= 33'd0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s1_valid;
      out_mag_q   <= mag_next;
      out_sat_q   <= sat_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_count_q <= 8'd0;
    end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != 8'hFF)) begin
      sat_count_q <= sat_count_q + 8'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_count = sat_count_q;
endmodule

// File: doc/log_mag_decode.md
LOG_MAG_DECODE -- requirements
Module: log_mag_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the input code is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the code this cycle.
REQ-005 SHALL have port in_exp, input, 6 bits, unsigned: floor(log2) of the magnitude-squared.
REQ-006 SHALL have port in_frac, input, 8 bits, unsigned: the fraction byte produced by the log-magnitude encoder.
REQ-007 SHALL have port out_valid, output, 1 bit: out_mag and out_sat are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream block accepts the output.
REQ-009 SHALL have port out_mag, output, 33 bits, unsigned: the reconstructed linear magnitude-squared.
REQ-010 SHALL have port out_sat, output, 1 bit: the output was saturated.
REQ-011 SHALL have port sat_count, output, 8 bits: saturating count of saturated outputs delivered.

Function
REQ-012 SHALL apply this transfer rule on each port: a transfer occurs when valid and ready are both high on the same rising edge.
REQ-013 SHALL have global enable en = !out_valid || out_ready, and SHALL drive in_ready = en combinationally.
REQ-014 SHALL be a 2-stage pipeline:
- stage 1 registers in_exp, in_frac and in_valid.
- stage 2 computes and registers out_mag, out_sat and out_valid.
- both stages update only when en is high.
REQ-015 SHALL have a latency of exactly 2 cycles from input transfer to out_valid, provided out_ready is held high; throughput SHALL then be 1 code per cycle.
REQ-016 SHALL, while en is low, hold every pipeline register, out_mag, out_sat and out_valid stable; no code SHALL be lost or duplicated.
REQ-017 SHALL allow a stall even when stage 1 holds a bubble; stage 1 does not advance independently.
REQ-018 SHALL compute the mantissa m = 256 + in_frac, 9 bits.
REQ-019 SHALL set out_mag = zero-extended in_frac when in_exp < 8 (exact small values); out_sat = 0.
REQ-020 SHALL set out_mag = m << (in_exp - 8) when 8 <= in_exp <= 32 (truncating, no rounding); out_sat = 0.
REQ-021 SHALL set out_mag = 33'h1_FFFF_FFFF and out_sat = 1 when in_exp > 32.
REQ-022 SHALL evaluate the boundary in_exp = 8 as m << 0, so in_frac = 0 gives 256.
REQ-023 SHALL evaluate in_exp = 32, in_frac = 0xFF as 0x1_FF00_0000 with no saturation.
REQ-024 SHALL increment sat_count by 1 on each output transfer with out_sat = 1, and SHALL hold it at 255 once reached.
REQ-025 SHALL not change sat_count on stalled cycles or bubbles.
REQ-026 SHALL take the pipeline data path only when in_valid is high; values captured while in_valid is low SHALL be don't-care and SHALL never be presented with out_valid = 1.

Reset
REQ-027 SHALL, while resetn is low, immediately (asynchronously) clear:
- stage-1 valid, exp and frac;
- out_valid, out_mag, out_sat and sat_count.
REQ-028 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.
REQ-029 SHALL discard any in-flight codes on reset mid-stream; the first output after reset release SHALL come from an input accepted after release.
REQ-030 SHALL, after reset release, allow the first input transfer on the first rising edge where resetn is high.

Verification
REQ-031 SHALL show: in_exp = 10, in_frac = 0x80, out_ready = 1 -> 2 cycles later out_valid = 1, out_mag = 0x600, out_sat = 0.
REQ-032 SHALL show: in_exp = 5, in_frac = 0x1F -> out_mag = 0x1F; then in_exp = 8, in_frac = 0x00 -> out_mag = 0x100; the two outputs arrive on consecutive cycles.
REQ-033 SHALL show: in_exp = 32, in_frac = 0xFF -> out_mag = 0x1_FF00_0000, out_sat = 0; in_exp = 40 -> out_mag = 0x1_FFFF_FFFF, out_sat = 1, sat_count 0 -> 1.
REQ-034 SHALL show:
- stimulus: stream codes 1..6, hold out_ready low 3 cycles while out_valid = 1;
- required: in_ready = 0 during the stall, out_mag stable, all 6 outputs delivered in order with none dropped or duplicated.
REQ-035 SHALL show: 300 consecutive in_exp = 63 transfers -> sat_count saturates at 255.
REQ-036 SHALL show: resetn pulsed low asynchronously (between edges) with 2 codes in flight -> out_valid, sat_count and out_mag read 0 immediately; no stale output after release.
